// File: rtl/bitout_pkg.sv
// Shared register map and STATUS bit positions for the bitout_n slave.
package bitout_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TOG    = 3'd3;
    localparam logic [2:0] ADDR_PLEN   = 3'd4;
    localparam logic [2:0] ADDR_PULSE  = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int STATUS_BUSY   = 0;
    localparam int STATUS_DONE   = 1;
    localparam int STATUS_IRQ_EN = 2;

endpackage

// File: rtl/bitout_pulse_timer.sv
// Down-counter for timed pulses: loads a length, counts to zero, flags the 1->0 step.
module bitout_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             cancel,
    output logic             tc,
    output logic             busy_cnt
);

    logic [CNT_W-1:0] cnt;

    // load beats cancel so a retrigger in a terminal-count cycle starts fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (cancel) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc       = (cnt == CNT_W'(1));
    assign busy_cnt = (cnt != '0);

endmodule

// File: rtl/bitout_n.sv
// Avalon-MM bit output register with set/clear/toggle and timed self-clearing pulses.
module bitout_n
    import bitout_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic [2:0]  avs_s1_address,
    input  logic        avs_s1_read,
    output logic [31:0] avs_s1_readdata,
    input  logic        avs_s1_write,
    input  logic [31:0] avs_s1_writedata,
    output logic [WIDTH-1:0] coe_bits,
    output logic        ins_irq
);

    // Bus: zero-wait-state slave. A write commits on the rising edge where
    // avs_s1_write is high; reads are combinational and side-effect free.

    logic [WIDTH-1:0] out_q, out_tc, out_next;
    logic [WIDTH-1:0] mask_q, mask_tc, mask_next;
    logic [CNT_W-1:0] plen_q;
    logic             done_q, done_next;
    logic             irq_en_q;
    logic             load, cancel, tc, busy_cnt;
    logic [WIDTH-1:0] wr_mask;
    logic             unused_bits;

    assign wr_mask     = avs_s1_writedata[WIDTH-1:0];
    assign unused_bits = ^{busy_cnt, avs_s1_writedata};

    bitout_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (csi_clk),
        .reset    (csi_reset),
        .load     (load),
        .len      (plen_q),
        .cancel   (cancel),
        .tc       (tc),
        .busy_cnt (busy_cnt)
    );

    // Terminal-count clear is applied first, then any bus write on top of it.
    always_comb begin
        out_tc    = out_q;
        mask_tc   = mask_q;
        out_next  = out_q;
        mask_next = mask_q;
        load      = 1'b0;
        cancel    = 1'b0;
        done_next = done_q;
        if (tc) begin
            out_tc  = out_q & ~mask_q;
            mask_tc = '0;
        end
        out_next  = out_tc;
        mask_next = mask_tc;
        if (avs_s1_write && avs_s1_address == ADDR_STATUS && avs_s1_writedata[STATUS_DONE])
            done_next = 1'b0;
        if (tc)
            done_next = 1'b1;
        if (avs_s1_write) begin
            case (avs_s1_address)
                ADDR_DATA: begin
                    out_next  = wr_mask;
                    mask_next = '0;
                    cancel    = 1'b1;
                end
                ADDR_SET: begin
                    out_next  = out_tc | wr_mask;
                    mask_next = mask_tc & ~wr_mask;
                    cancel    = (mask_next == '0);
                end
                ADDR_CLR: begin
                    out_next  = out_tc & ~wr_mask;
                    mask_next = mask_tc & ~wr_mask;
                    cancel    = (mask_next == '0);
                end
                ADDR_TOG: begin
                    out_next  = out_tc ^ wr_mask;
                    mask_next = mask_tc & ~wr_mask;
                    cancel    = (mask_next == '0);
                end
                ADDR_PULSE: begin
                    if (plen_q != '0 && wr_mask != '0) begin
                        out_next  = out_tc | wr_mask;
                        mask_next = mask_tc | wr_mask;
                        load      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            out_q    <= RESET_VALUE;
            mask_q   <= '0;
            plen_q   <= '0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            out_q  <= out_next;
            mask_q <= mask_next;
            done_q <= done_next;
            if (avs_s1_write && avs_s1_address == ADDR_PLEN)
                plen_q <= avs_s1_writedata[CNT_W-1:0];
            if (avs_s1_write && avs_s1_address == ADDR_STATUS)
                irq_en_q <= avs_s1_writedata[STATUS_IRQ_EN];
        end
    end

    always_comb begin
        avs_s1_readdata = '0;
        if (avs_s1_read) begin
            case (avs_s1_address)
                ADDR_DATA:  avs_s1_readdata[WIDTH-1:0] = out_q;
                ADDR_PLEN:  avs_s1_readdata[CNT_W-1:0] = plen_q;
                ADDR_PULSE: avs_s1_readdata[WIDTH-1:0] = mask_q;
                ADDR_STATUS: begin
                    avs_s1_readdata[STATUS_BUSY]   = (mask_q != '0);
                    avs_s1_readdata[STATUS_DONE]   = done_q;
                    avs_s1_readdata[STATUS_IRQ_EN] = irq_en_q;
                end
                default: ;
            endcase
        end
    end

    assign coe_bits = out_q;
    assign ins_irq  = done_q & irq_en_q;

endmodule

// File: tb/tb_bitout_n.sv
// Directed bench for bitout_n: register ops, timed pulses, edge collisions, reset abort.
module tb_bitout_n;

    logic        csi_clk;
    logic        csi_reset;
    logic [2:0]  avs_s1_address;
    logic        avs_s1_read;
    logic [31:0] avs_s1_readdata;
    logic        avs_s1_write;
    logic [31:0] avs_s1_writedata;
    logic [7:0]  coe_bits;
    logic        ins_irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rdv;

    bitout_n #(.WIDTH(8), .CNT_W(16), .RESET_VALUE(8'hA5)) dut (
        .csi_clk          (csi_clk),
        .csi_reset        (csi_reset),
        .avs_s1_address   (avs_s1_address),
        .avs_s1_read      (avs_s1_read),
        .avs_s1_readdata  (avs_s1_readdata),
        .avs_s1_write     (avs_s1_write),
        .avs_s1_writedata (avs_s1_writedata),
        .coe_bits         (coe_bits),
        .ins_irq          (ins_irq)
    );

    initial csi_clk = 1'b0;
    always #5 csi_clk = ~csi_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge csi_clk);
        avs_s1_address   = a;
        avs_s1_writedata = d;
        avs_s1_write     = 1'b1;
        @(posedge csi_clk);
        #1;
        avs_s1_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_s1_address = a;
        avs_s1_read    = 1'b1;
        #1;
        d = avs_s1_readdata;
        avs_s1_read = 1'b0;
    endtask

    task automatic tick();
        @(posedge csi_clk);
        #1;
    endtask

    initial begin
        csi_reset        = 1'b1;
        avs_s1_address   = 3'd0;
        avs_s1_read      = 1'b0;
        avs_s1_write     = 1'b0;
        avs_s1_writedata = 32'h0;

        // reset state
        #3;
        check("rst_bits", coe_bits, 32'hA5);
        check("rst_irq", ins_irq, 32'h0);
        bus_read(3'd0, rdv); check("rst_rd_data", rdv, 32'h0000_00A5);
        bus_read(3'd6, rdv); check("rst_rd_status", rdv, 32'h0);
        @(negedge csi_clk);
        csi_reset = 1'b0;

        // set / clear / toggle
        bus_write(3'd0, 32'h0F); check("data_0f", coe_bits, 32'h0F);
        bus_write(3'd1, 32'h30); check("set_30", coe_bits, 32'h3F);
        bus_write(3'd2, 32'h01); check("clr_01", coe_bits, 32'h3E);
        bus_write(3'd3, 32'h81); check("tog_81", coe_bits, 32'hBF);
        bus_read(3'd1, rdv); check("rd_set_zero", rdv, 32'h0);
        bus_read(3'd2, rdv); check("rd_clr_zero", rdv, 32'h0);
        bus_read(3'd3, rdv); check("rd_tog_zero", rdv, 32'h0);
        tick();
        bus_read(3'd7, rdv); check("rd_rsvd_zero", rdv, 32'h0);
        bus_read(3'd0, rdv); check("rd_data_bf", rdv, 32'hBF);

        // 5-cycle pulse on bit 2 with irq
        bus_write(3'd0, 32'h00);
        bus_write(3'd4, 32'h5);
        bus_read(3'd4, rdv); check("rd_plen5", rdv, 32'h5);
        bus_write(3'd6, 32'h4);
        bus_write(3'd5, 32'h04);
        check("p5_start", coe_bits, 32'h04);
        bus_read(3'd6, rdv); check("p5_status_busy", rdv, 32'h5);
        bus_read(3'd5, rdv); check("p5_mask", rdv, 32'h04);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p5_hold", coe_bits, 32'h04);
            check("p5_irq_low", ins_irq, 32'h0);
            bus_read(3'd6, rdv); check("p5_busy", rdv, 32'h5);
        end
        tick();
        check("p5_end_bits", coe_bits, 32'h00);
        check("p5_end_irq", ins_irq, 32'h1);
        bus_read(3'd6, rdv); check("p5_end_status", rdv, 32'h6);
        bus_write(3'd6, 32'h2);
        check("p5_irq_cleared", ins_irq, 32'h0);
        bus_read(3'd6, rdv); check("p5_status_clr", rdv, 32'h0);

        // retrigger: bit0 at cycle 0, bit1 at cycle 4, both clear at cycle 14
        bus_write(3'd4, 32'd10);
        bus_write(3'd5, 32'h01);
        check("rt_start", coe_bits, 32'h01);
        tick(); tick(); tick();
        bus_write(3'd5, 32'h02);
        check("rt_second", coe_bits, 32'h03);
        bus_read(3'd5, rdv); check("rt_mask", rdv, 32'h03);
        for (int i = 0; i < 9; i++) tick();
        check("rt_hold_c13", coe_bits, 32'h03);
        tick();
        check("rt_clear_c14", coe_bits, 32'h00);
        bus_read(3'd6, rdv); check("rt_done", rdv, 32'h2);
        bus_write(3'd6, 32'h2);

        // CLR during a pulse cancels it without done
        bus_write(3'd5, 32'h03);
        tick(); tick();
        bus_write(3'd2, 32'h03);
        check("cancel_bits", coe_bits, 32'h00);
        bus_read(3'd6, rdv); check("cancel_status", rdv, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        bus_read(3'd6, rdv); check("cancel_no_done", rdv, 32'h0);

        // TOG on the pulsed bit in the terminal-count cycle
        bus_write(3'd4, 32'd3);
        bus_write(3'd5, 32'h01);
        tick(); tick();
        bus_write(3'd3, 32'h01);
        check("tc_tog_bits", coe_bits, 32'h01);
        bus_read(3'd6, rdv); check("tc_tog_status", rdv, 32'h2);
        for (int i = 0; i < 4; i++) tick();
        check("tc_tog_stays", coe_bits, 32'h01);

        // PULSE in the terminal-count cycle starts a fresh pulse, done still set
        bus_write(3'd6, 32'h2);
        bus_write(3'd0, 32'h00);
        bus_write(3'd5, 32'h01);
        tick(); tick();
        bus_write(3'd5, 32'h02);
        check("tc_pulse_bits", coe_bits, 32'h02);
        bus_read(3'd6, rdv); check("tc_pulse_status", rdv, 32'h3);
        tick(); tick();
        check("tc_pulse_hold", coe_bits, 32'h02);
        tick();
        check("tc_pulse_end", coe_bits, 32'h00);

        // done-clear write in the terminal-count cycle: set wins
        bus_write(3'd5, 32'h08);
        tick(); tick();
        bus_write(3'd6, 32'h2);
        check("setwins_bits", coe_bits, 32'h00);
        bus_read(3'd6, rdv); check("setwins_done", rdv, 32'h2);

        // ignored pulses: zero mask, zero length
        bus_write(3'd5, 32'h00);
        bus_read(3'd6, rdv); check("ign_mask0", rdv, 32'h2);
        bus_write(3'd4, 32'h0);
        bus_write(3'd5, 32'h10);
        check("ign_plen0_bits", coe_bits, 32'h00);
        bus_read(3'd6, rdv); check("ign_plen0_status", rdv, 32'h2);

        // reset in the middle of an 8-cycle pulse
        bus_write(3'd4, 32'd8);
        bus_write(3'd6, 32'h6);
        bus_write(3'd5, 32'h40);
        check("rp_start", coe_bits, 32'h40);
        tick(); tick();
        #1 csi_reset = 1'b1;
        #1;
        check("rp_bits_async", coe_bits, 32'hA5);
        check("rp_irq", ins_irq, 32'h0);
        bus_read(3'd6, rdv); check("rp_status_in_rst", rdv, 32'h0);
        @(negedge csi_clk);
        csi_reset        = 1'b0;
        avs_s1_address   = 3'd0;
        avs_s1_writedata = 32'h5A;
        avs_s1_write     = 1'b1;
        @(posedge csi_clk);
        #1;
        avs_s1_write = 1'b0;
        check("first_write", coe_bits, 32'h5A);
        bus_read(3'd4, rdv); check("rp_plen0", rdv, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        bus_read(3'd6, rdv); check("rp_no_done", rdv, 32'h0);
        check("rp_irq_after", ins_irq, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
